inst_fetch: RTL and testbench

Instruction fetch unit for the RV64 NPC core. Holds the 64-bit PC, issues 32-bit instruction reads to instruction memory over a valid/ready request channel and a valid-only response channel, and presents each fetched instruction with its PC to the decode stage through a valid/ready handshake. It accepts PC redirects from jump/branch resolution and stops fetching on halt (ebreak). It is the producer of the `inst` word that the decoder consumes.

---
 rtl/inst_fetch_if.sv | 32 +++
 rtl/inst_fetch.sv | 137 +++++++++++++
 tb/tb_inst_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction memory request/response channels, the decode
// handshake, redirect/halt controls and the misalignment flag.
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt;
  logic                  fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/inst_fetch.sv
// RV64 instruction fetch: one outstanding imem request, single-entry decode
// buffer, redirect with in-flight response drop, halt with drain.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
  input logic         clk,
  input logic         rst_n,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc, req_addr;
  logic [INST_WIDTH-1:0] inst_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;
  logic                  req_valid, inst_valid_q, drop, halt_pend, misalign;

  logic                  mis, stop, hs;
  logic [ADDR_WIDTH-1:0] pc_inc, npc;

  assign mis    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign stop   = bus.halt || mis;
  assign hs     = req_valid && bus.imem_req_ready;
  assign pc_inc = pc + ADDR_WIDTH'(4);
  assign npc    = bus.redirect_valid ? bus.redirect_pc : pc;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_misalign = misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      req_valid    <= 1'b0;
      inst_valid_q <= 1'b0;
      drop         <= 1'b0;
      halt_pend    <= 1'b0;
      misalign     <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (stop) begin
            misalign  <= misalign || mis;
            req_valid <= 1'b0;
            if (hs) begin
              drop      <= 1'b1;
              halt_pend <= 1'b1;
              state     <= S_WAIT;
            end else begin
              state     <= S_HALT;
            end
          end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
            if (hs) begin
              drop      <= 1'b1;
              req_valid <= 1'b0;
              state     <= S_WAIT;
            end else if (req_valid) begin
              // Address must stay stable; let the old fetch finish and discard it.
              drop <= 1'b1;
            end else begin
              req_addr  <= bus.redirect_pc;
              req_valid <= 1'b1;
            end
          end else if (hs) begin
            req_valid <= 1'b0;
            state     <= S_WAIT;
          end else if (!req_valid) begin
            req_addr  <= pc;
            req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (halt_pend || stop) begin
              if (!halt_pend) misalign <= misalign || mis;
              state <= S_HALT;
            end else if (drop || bus.redirect_valid) begin
              drop      <= 1'b0;
              pc        <= npc;
              req_addr  <= npc;
              req_valid <= 1'b1;
              state     <= S_REQ;
            end else begin
              inst_q       <= bus.imem_rsp_data;
              inst_pc_q    <= pc;
              inst_valid_q <= 1'b1;
              state        <= S_HOLD;
            end
          end else if (!halt_pend) begin
            if (stop) begin
              misalign  <= misalign || mis;
              halt_pend <= 1'b1;
              drop      <= 1'b1;
            end else if (bus.redirect_valid) begin
              pc   <= bus.redirect_pc;
              drop <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (stop) begin
            misalign     <= misalign || mis;
            inst_valid_q <= 1'b0;
            state        <= S_HALT;
          end else if (bus.redirect_valid) begin
            // Redirect wins over a same-cycle consume: no pc+4.
            pc           <= bus.redirect_pc;
            req_addr     <= bus.redirect_pc;
            req_valid    <= 1'b1;
            inst_valid_q <= 1'b0;
            state        <= S_REQ;
          end else if (bus.inst_ready) begin
            pc           <= pc_inc;
            req_addr     <= pc_inc;
            req_valid    <= 1'b1;
            inst_valid_q <= 1'b0;
            state        <= S_REQ;
          end
        end
        default: begin
          req_valid    <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a configurable-latency instruction memory.
module tb_inst_fetch;
  localparam int AW = 64;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus();

  inst_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int cnt;
  int req_cnt = 0;
  int iv_cnt = 0;
  logic [AW-1:0] pend;
  logic [AW-1:0] acc_addr[$];
  int            acc_cyc[$];
  logic [AW-1:0] pres_pc[$];
  logic [IW-1:0] pres_inst[$];

  // Memory contents: addi x0,x0,imm with imm = low 12 address bits.
  function automatic logic [IW-1:0] mem_word(logic [AW-1:0] a);
    return 32'h0000_0013 | {a[11:0], 20'h0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
      cnt                <= 0;
      pend               <= '0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      if (cnt == 1) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= mem_word(pend);
      end
      if (cnt != 0) cnt <= cnt - 1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        acc_addr.push_back(bus.imem_req_addr);
        acc_cyc.push_back(cyc);
        pend <= bus.imem_req_addr;
        if (mem_lat == 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_word(bus.imem_req_addr);
        end else begin
          cnt <= mem_lat - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_req_valid) req_cnt <= req_cnt + 1;
    if (bus.inst_valid) iv_cnt <= iv_cnt + 1;
    if (rst_n && bus.inst_valid && bus.inst_ready && !bus.redirect_valid && !bus.halt) begin
      pres_pc.push_back(bus.inst_pc);
      pres_inst.push_back(bus.inst);
    end
  end

  task automatic do_reset(input int lat);
    rst_n = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt = 1'b0;
    mem_lat = lat;
    repeat (2) @(negedge clk);
    acc_addr.delete(); acc_cyc.delete(); pres_pc.delete(); pres_inst.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input int n, input string name);
    int k = 0;
    while (acc_addr.size() < n && k < 200) begin @(negedge clk); k++; end
    if (acc_addr.size() < n) begin
      errors++;
      $display("FAIL %s timeout: requests %0d want %0d", name, acc_addr.size(), n);
    end
  endtask

  task automatic wait_iv(input string name);
    int k = 0;
    while (bus.inst_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (bus.inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout waiting inst_valid", name);
    end
  endtask

  task automatic test_reset();
    do_reset(1);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b want 0", bus.inst_valid); end
    checks++; if (bus.fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", bus.fetch_misalign); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", bus.inst); end
    checks++; if (bus.inst_pc !== 64'h0) begin errors++; $display("FAIL reset_inst_pc got %h want 0", bus.inst_pc); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL first_req_addr got %h want 80000000", bus.imem_req_addr); end
  endtask

  task automatic test_straight_line();
    do_reset(1);
    bus.inst_ready = 1'b1;
    wait_acc(3, "straight");
    checks++; if (acc_addr[0] !== 64'h8000_0000) begin errors++; $display("FAIL straight_addr0 got %h want 80000000", acc_addr[0]); end
    checks++; if (acc_addr[1] !== 64'h8000_0004) begin errors++; $display("FAIL straight_addr1 got %h want 80000004", acc_addr[1]); end
    checks++; if (acc_addr[2] !== 64'h8000_0008) begin errors++; $display("FAIL straight_addr2 got %h want 80000008", acc_addr[2]); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 3) begin errors++; $display("FAIL straight_spacing01 got %0d want 3", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (acc_cyc[2] - acc_cyc[1] != 3) begin errors++; $display("FAIL straight_spacing12 got %0d want 3", acc_cyc[2] - acc_cyc[1]); end
    checks++; if (pres_pc[0] !== 64'h8000_0000 || pres_inst[0] !== 32'h0000_0013) begin errors++; $display("FAIL straight_pres0 got %h/%h want 80000000/00000013", pres_pc[0], pres_inst[0]); end
    checks++; if (pres_pc[1] !== 64'h8000_0004 || pres_inst[1] !== 32'h0040_0013) begin errors++; $display("FAIL straight_pres1 got %h/%h want 80000004/00400013", pres_pc[1], pres_inst[1]); end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    wait_iv("backpressure");
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.inst !== 32'h0000_0013 || bus.inst_pc !== 64'h8000_0000) begin errors++; $display("FAIL bp_stable[%0d] got %h/%h want 00000013/80000000", i, bus.inst, bus.inst_pc); end
      checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] req_valid %b inst_valid %b want 0/1", i, bus.imem_req_valid, bus.inst_valid); end
      @(negedge clk);
    end
    checks++; if (acc_addr.size() != 1) begin errors++; $display("FAIL bp_no_req got %0d requests want 1", acc_addr.size()); end
    bus.inst_ready = 1'b1;
    wait_acc(2, "bp_release");
    checks++; if (acc_addr[1] !== 64'h8000_0004) begin errors++; $display("FAIL bp_next_addr got %h want 80000004", acc_addr[1]); end
  endtask

  task automatic test_redirect_wait();
    int found = 0;
    int k = 0;
    do_reset(3);
    bus.inst_ready = 1'b1;
    wait_acc(2, "rw");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_acc(3, "rw_target");
    checks++; if (acc_addr[2] !== 64'h8000_0100) begin errors++; $display("FAIL rw_next_addr got %h want 80000100", acc_addr[2]); end
    while (pres_pc.size() < 2 && k < 50) begin @(negedge clk); k++; end
    checks++; if (pres_pc[1] !== 64'h8000_0100 || pres_inst[1] !== 32'h1000_0013) begin errors++; $display("FAIL rw_target_inst got %h/%h want 80000100/10000013", pres_pc[1], pres_inst[1]); end
    foreach (pres_pc[i]) if (pres_pc[i] == 64'h8000_0004) found++;
    checks++; if (found != 0) begin errors++; $display("FAIL rw_dropped got %0d presentations of 80000004 want 0", found); end
  endtask

  task automatic test_redirect_hold();
    do_reset(1);
    wait_iv("rh");
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rh_inst_valid got %b want 0", bus.inst_valid); end
    wait_acc(2, "rh_target");
    checks++; if (acc_addr[1] !== 64'h8000_0100) begin errors++; $display("FAIL rh_next_addr got %h want 80000100", acc_addr[1]); end
    checks++; if (pres_pc.size() != 0) begin errors++; $display("FAIL rh_consumed got %0d want 0", pres_pc.size()); end
  endtask

  task automatic test_halt();
    do_reset(3);
    bus.inst_ready = 1'b1;
    wait_acc(1, "halt");
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt = 1'b0;
    req_cnt = 0;
    iv_cnt = 0;
    repeat (20) @(negedge clk);
    checks++; if (acc_addr.size() != 1) begin errors++; $display("FAIL halt_requests got %0d want 1", acc_addr.size()); end
    checks++; if (req_cnt != 0) begin errors++; $display("FAIL halt_req_valid_cycles got %0d want 0", req_cnt); end
    checks++; if (iv_cnt != 0) begin errors++; $display("FAIL halt_inst_valid_cycles got %0d want 0", iv_cnt); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (acc_addr.size() != 1 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_redirect requests %0d req_valid %b want 1/0", acc_addr.size(), bus.imem_req_valid); end
  endtask

  task automatic test_misalign();
    do_reset(1);
    wait_iv("mis");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0102;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++; if (bus.fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", bus.fetch_misalign); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mis_inst_valid got %b want 0", bus.inst_valid); end
    bus.inst_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (bus.fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b want 1", bus.fetch_misalign); end
    checks++; if (acc_addr.size() != 1 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_stopped requests %0d req_valid %b want 1/0", acc_addr.size(), bus.imem_req_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_reset_clear got %b want 0", bus.fetch_misalign); end
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_halt();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
